myo_spi_scheduler: RTL and testbench

MYO_SPI_SCHEDULER -- requirements
Module: myo_spi_scheduler

---
 rtl/myo_pkg.sv | 18 +
 rtl/myo_prio_select.sv | 36 +++
 rtl/myo_spi_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_myo_spi_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myo_pkg.sv
// Shared definitions for the myocontrol SPI scheduler.
//   NUM_MOTORS_DEF : default number of slave selects swept per port
//   IDX_W          : width of the externally visible motor index
//   state_e        : scheduler FSM states
package myo_pkg;

  localparam int unsigned NUM_MOTORS_DEF = 7;
  localparam int unsigned IDX_W          = 3;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETUP,
    WAIT_DONE,
    NEXT
  } state_e;

endpackage

// File: rtl/myo_prio_select.sv
// Combinational selector: finds the lowest set bit of mask_i whose position
// is at or above start_i.
//   mask_i  : motors still eligible in this sweep
//   start_i : first position to consider (one bit wider than the motor index
//             so that "past the last motor" can be represented)
//   valid_o : a qualifying bit exists
//   idx_o   : position of that bit (0 when valid_o is low)
module myo_prio_select
  import myo_pkg::*;
#(
  parameter int unsigned NUM_MOTORS = NUM_MOTORS_DEF
) (
  input  logic [NUM_MOTORS-1:0] mask_i,
  input  logic [IDX_W:0]        start_i,
  output logic                  valid_o,
  output logic [IDX_W:0]        idx_o
);

  logic          found;
  logic [IDX_W:0] idx;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < NUM_MOTORS; i++) begin
      if (!found && mask_i[i] && (i >= 32'(start_i))) begin
        found = 1'b1;
        idx   = i[IDX_W:0];
      end
    end
  end

  assign valid_o = found;
  assign idx_o   = idx;

endmodule

// File: rtl/myo_spi_scheduler.sv
// Periodic SPI sweep scheduler for one myocontrol port. Every update_period
// cycles it visits each enabled motor: assert its slave select, wait SS_SETUP
// cycles, pulse spi_start, wait for spi_done (or TIMEOUT), deselect, move on.
//   clock, reset_n  : clock and synchronous active-low reset
//   update_period   : cycles between sweep starts (0 = no periodic sweeps)
//   enable_mask     : motors to visit, latched at sweep start
//   power_sense_n   : low while motor power is present; high aborts everything
//   spi_start       : one-cycle start pulse to the SPI master
//   spi_done        : one-cycle completion pulse from the SPI master
//   ss_n            : active-low slave selects (at most one low)
//   motor_index     : motor currently being serviced
//   sweep_done      : one-cycle pulse at the end of each sweep
//   timeout_err     : sticky per-motor timeout flags
//   overrun         : sticky, period expired while a sweep was already pending
//   clear_flags     : clears timeout_err and overrun (a same-cycle set wins)
module myo_spi_scheduler
  import myo_pkg::*;
#(
  parameter int unsigned NUM_MOTORS = NUM_MOTORS_DEF,
  parameter int unsigned SS_SETUP   = 4,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [31:0]           update_period,
  input  logic [NUM_MOTORS-1:0] enable_mask,
  input  logic                  power_sense_n,
  output logic                  spi_start,
  input  logic                  spi_done,
  output logic [NUM_MOTORS-1:0] ss_n,
  output logic [IDX_W-1:0]      motor_index,
  output logic                  sweep_done,
  output logic [NUM_MOTORS-1:0] timeout_err,
  output logic                  overrun,
  input  logic                  clear_flags
);

  state_e                  state_q;
  logic [IDX_W:0]          idx_q;
  logic [NUM_MOTORS-1:0]   mask_q;
  logic [31:0]             setup_cnt_q;
  logic [31:0]             tmo_cnt_q;
  logic [NUM_MOTORS-1:0]   ss_n_q;
  logic                    spi_start_q;
  logic                    sweep_done_q;

  logic [31:0]             per_cnt_q, per_cnt_d;
  logic [31:0]             per_q;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic [NUM_MOTORS-1:0]   timeout_err_q, timeout_err_d;

  logic                    sel_valid;
  logic [IDX_W:0]          sel_idx;
  logic [NUM_MOTORS-1:0]   sel_bit;
  logic [NUM_MOTORS-1:0]   cur_bit;
  logic                    per_changed;
  logic                    wrap;
  logic                    consume;
  logic                    tmo_fire;

  myo_prio_select #(
    .NUM_MOTORS (NUM_MOTORS)
  ) u_prio_select (
    .mask_i  (mask_q),
    .start_i (idx_q),
    .valid_o (sel_valid),
    .idx_o   (sel_idx)
  );

  assign sel_bit = NUM_MOTORS'(1) << sel_idx;
  assign cur_bit = NUM_MOTORS'(1) << idx_q;

  // per_q holds last cycle's period so a change restarts the count from 0.
  assign per_changed = (update_period != per_q);
  assign wrap        = !per_changed && (update_period != '0) &&
                       (per_cnt_q == update_period - 32'd1);
  assign consume     = (state_q == IDLE) && pending_q && !power_sense_n;
  assign tmo_fire    = (state_q == WAIT_DONE) && !spi_done && !power_sense_n &&
                       (tmo_cnt_q == 32'(TIMEOUT - 1));

  always_comb begin
    per_cnt_d = per_cnt_q + 32'd1;
    if (per_changed || (update_period == '0) || wrap) begin
      per_cnt_d = '0;
    end

    // A wrap landing on the cycle IDLE takes the pending request is a fresh
    // request for the next sweep, not an overrun.
    pending_d = pending_q;
    overrun_d = clear_flags ? 1'b0 : overrun_q;
    if (consume) begin
      pending_d = 1'b0;
    end
    if (wrap) begin
      if (pending_q && !consume) begin
        overrun_d = 1'b1;
      end
      pending_d = 1'b1;
    end
    if (power_sense_n) begin
      pending_d = 1'b0;
    end

    timeout_err_d = clear_flags ? '0 : timeout_err_q;
    if (tmo_fire) begin
      timeout_err_d = timeout_err_d | cur_bit;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      per_cnt_q     <= '0;
      per_q         <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= '0;
    end else begin
      per_cnt_q     <= per_cnt_d;
      per_q         <= update_period;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      mask_q       <= '0;
      setup_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
      ss_n_q       <= '1;
      spi_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;
    end else if (power_sense_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      ss_n_q       <= '1;
      spi_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      spi_start_q  <= 1'b0;
      sweep_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            mask_q  <= enable_mask;
            state_q <= SELECT;
          end
        end
        SELECT: begin
          if (sel_valid) begin
            idx_q       <= sel_idx;
            ss_n_q      <= ~sel_bit;
            setup_cnt_q <= '0;
            state_q     <= SETUP;
          end else begin
            sweep_done_q <= 1'b1;
            idx_q        <= '0;
            state_q      <= IDLE;
          end
        end
        SETUP: begin
          if (setup_cnt_q == 32'(SS_SETUP - 1)) begin
            spi_start_q <= 1'b1;
            tmo_cnt_q   <= '0;
            state_q     <= WAIT_DONE;
          end else begin
            setup_cnt_q <= setup_cnt_q + 32'd1;
          end
        end
        WAIT_DONE: begin
          if (spi_done || tmo_fire) begin
            state_q <= NEXT;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 32'd1;
          end
        end
        NEXT: begin
          ss_n_q  <= '1;
          idx_q   <= idx_q + 1'b1;
          state_q <= SELECT;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_start   = spi_start_q;
  assign ss_n        = ss_n_q;
  assign motor_index = idx_q[IDX_W-1:0];
  assign sweep_done  = sweep_done_q;
  assign timeout_err = timeout_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_myo_spi_scheduler.sv
// Directed bench for myo_spi_scheduler with a simple SPI master responder.
module tb_myo_spi_scheduler;

  logic        clock;
  logic        reset_n;
  logic [31:0] update_period;
  logic [6:0]  enable_mask;
  logic        power_sense_n;
  logic        spi_start;
  logic        spi_done;
  logic [6:0]  ss_n;
  logic [2:0]  motor_index;
  logic        sweep_done;
  logic [6:0]  timeout_err;
  logic        overrun;
  logic        clear_flags;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int n_start      = 0;
  int n_sweep      = 0;
  int n_viol       = 0;

  int   resp_delay = 0;
  logic stray_en   = 1'b0;
  logic flush      = 1'b0;

  myo_spi_scheduler #(
    .NUM_MOTORS (7),
    .SS_SETUP   (4),
    .TIMEOUT    (4096)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .update_period (update_period),
    .enable_mask   (enable_mask),
    .power_sense_n (power_sense_n),
    .spi_start     (spi_start),
    .spi_done      (spi_done),
    .ss_n          (ss_n),
    .motor_index   (motor_index),
    .sweep_done    (sweep_done),
    .timeout_err   (timeout_err),
    .overrun       (overrun),
    .clear_flags   (clear_flags)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // SPI master: answers each spi_start with a one-cycle spi_done resp_delay
  // cycles later (resp_delay 0 = never answers).
  initial begin
    int cd;
    cd       = 0;
    spi_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      spi_done = 1'b0;
      if (flush) cd = 0;
      if (stray_en) spi_done = 1'b1;
      if (cd > 0) begin
        cd--;
        if (cd == 0) spi_done = 1'b1;
      end
      if (spi_start && resp_delay > 0) cd = resp_delay;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (spi_start) n_start++;
    if (sweep_done) n_sweep++;
    if ($countones(~ss_n) > 1) n_viol++;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    update_period = '0;
    enable_mask   = '0;
    power_sense_n = 1'b0;
    clear_flags   = 1'b0;
    resp_delay    = 0;
    stray_en      = 1'b0;
    flush         = 1'b1;
    step();
    step();
    flush   = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    update_period = 32'd5;
    enable_mask   = 7'h7F;
    power_sense_n = 1'b0;
    clear_flags   = 1'b0;
    repeat (3) step();
    tests_run++;
    if (ss_n !== 7'h7F) begin tests_failed++; $display("FAIL reset_ss_n: got %h expected 7f", ss_n); end
    tests_run++;
    if (spi_start !== 1'b0) begin tests_failed++; $display("FAIL reset_spi_start: got %b expected 0", spi_start); end
    tests_run++;
    if (sweep_done !== 1'b0) begin tests_failed++; $display("FAIL reset_sweep_done: got %b expected 0", sweep_done); end
    tests_run++;
    if (motor_index !== 3'd0) begin tests_failed++; $display("FAIL reset_motor_index: got %0d expected 0", motor_index); end
    tests_run++;
    if (timeout_err !== 7'h00) begin tests_failed++; $display("FAIL reset_timeout_err: got %h expected 00", timeout_err); end
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_sweep();
    int t_sel, t_d1, s0;
    do_reset();
    s0            = n_start;
    enable_mask   = 7'b0000101;
    resp_delay    = 20;
    update_period = 32'd1000;
    for (int i = 0; i < 1100 && ss_n == 7'h7F; i++) step();
    t_sel = cyc;
    tests_run++;
    if (ss_n !== 7'b1111110) begin tests_failed++; $display("FAIL sweep_sel0: ss_n got %b expected 1111110", ss_n); end
    tests_run++;
    if (motor_index !== 3'd0) begin tests_failed++; $display("FAIL sweep_idx0: got %0d expected 0", motor_index); end
    // latched mask must shield the running sweep from this change
    enable_mask = 7'h7F;
    for (int i = 0; i < 10 && !spi_start; i++) step();
    tests_run++;
    if (!spi_start || (cyc - t_sel) != 4) begin tests_failed++; $display("FAIL sweep_start0: start=%b after %0d cycles, expected 1 after 4", spi_start, cyc - t_sel); end
    for (int i = 0; i < 100 && ss_n != 7'h7F; i++) step();
    for (int i = 0; i < 10 && ss_n == 7'h7F; i++) step();
    t_sel = cyc;
    tests_run++;
    if (ss_n !== 7'b1111011) begin tests_failed++; $display("FAIL sweep_sel2: ss_n got %b expected 1111011", ss_n); end
    tests_run++;
    if (motor_index !== 3'd2) begin tests_failed++; $display("FAIL sweep_idx2: got %0d expected 2", motor_index); end
    for (int i = 0; i < 10 && !spi_start; i++) step();
    tests_run++;
    if (!spi_start || (cyc - t_sel) != 4) begin tests_failed++; $display("FAIL sweep_start2: start=%b after %0d cycles, expected 1 after 4", spi_start, cyc - t_sel); end
    for (int i = 0; i < 100 && !sweep_done; i++) step();
    t_d1 = cyc;
    tests_run++;
    if (sweep_done !== 1'b1 || (n_start - s0) != 2) begin tests_failed++; $display("FAIL sweep_done1: done=%b starts=%0d expected 1 and 2", sweep_done, n_start - s0); end
    tests_run++;
    if (ss_n !== 7'h7F) begin tests_failed++; $display("FAIL sweep_idle_ss: got %h expected 7f", ss_n); end
    enable_mask = 7'b0000101;
    step();
    for (int i = 0; i < 1100 && !sweep_done; i++) step();
    tests_run++;
    if (!sweep_done || (cyc - t_d1) != 1000) begin tests_failed++; $display("FAIL sweep_period: done=%b spacing %0d expected 1000", sweep_done, cyc - t_d1); end
    tests_run++;
    if ((n_start - s0) != 4) begin tests_failed++; $display("FAIL sweep_starts2: got %0d expected 4", n_start - s0); end
  endtask

  task automatic test_timeout();
    int t_st, t_to, s0;
    do_reset();
    s0            = n_start;
    enable_mask   = 7'b0000010;
    resp_delay    = 0;
    update_period = 32'd5000;
    for (int i = 0; i < 5100 && !spi_start; i++) step();
    t_st = cyc;
    tests_run++;
    if (!spi_start || motor_index !== 3'd1) begin tests_failed++; $display("FAIL tmo_start: start=%b idx=%0d expected 1 and 1", spi_start, motor_index); end
    for (int i = 0; i < 4200 && timeout_err == 7'h00; i++) step();
    t_to = cyc;
    tests_run++;
    if (timeout_err !== 7'b0000010) begin tests_failed++; $display("FAIL tmo_flag: got %b expected 0000010", timeout_err); end
    tests_run++;
    if ((t_to - t_st) != 4096) begin tests_failed++; $display("FAIL tmo_latency: got %0d expected 4096", t_to - t_st); end
    for (int i = 0; i < 10 && !sweep_done; i++) step();
    tests_run++;
    if (!sweep_done || (cyc - t_to) != 2) begin tests_failed++; $display("FAIL tmo_sweep_done: done=%b after %0d expected 1 after 2", sweep_done, cyc - t_to); end
    tests_run++;
    if ((n_start - s0) != 1) begin tests_failed++; $display("FAIL tmo_starts: got %0d expected 1", n_start - s0); end
    update_period = '0;
    clear_flags   = 1'b1;
    step();
    clear_flags = 1'b0;
    tests_run++;
    if (timeout_err !== 7'h00) begin tests_failed++; $display("FAIL tmo_clear: got %b expected 0000000", timeout_err); end
  endtask

  task automatic test_clear_priority();
    logic seen;
    do_reset();
    enable_mask   = 7'b0000001;
    resp_delay    = 0;
    clear_flags   = 1'b1;
    update_period = 32'd20;
    seen          = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin
      step();
      if (overrun) seen = 1'b1;
    end
    tests_run++;
    if (seen !== 1'b1) begin tests_failed++; $display("FAIL clr_set_wins: overrun seen=%b expected 1", seen); end
    step();
    tests_run++;
    if (overrun !== 1'b0) begin tests_failed++; $display("FAIL clr_clears: overrun got %b expected 0", overrun); end
    clear_flags = 1'b0;
    repeat (25) step();
    tests_run++;
    if (overrun !== 1'b1) begin tests_failed++; $display("FAIL clr_sticky: overrun got %b expected 1", overrun); end
  endtask

  task automatic test_back_to_back();
    int t1, t2, s0;
    do_reset();
    enable_mask   = 7'h7F;
    resp_delay    = 100;
    update_period = 32'd50;
    for (int i = 0; i < 1000 && !sweep_done; i++) step();
    t1 = cyc;
    s0 = n_start;
    for (int i = 0; i < 5 && ss_n == 7'h7F; i++) step();
    tests_run++;
    if (ss_n !== 7'b1111110 || (cyc - t1) != 2) begin tests_failed++; $display("FAIL b2b_gap1: ss_n=%b after %0d expected 1111110 after 2", ss_n, cyc - t1); end
    for (int i = 0; i < 900 && !sweep_done; i++) step();
    t2 = cyc;
    tests_run++;
    if (!sweep_done || (t2 - t1) != 751) begin tests_failed++; $display("FAIL b2b_len1: done=%b spacing %0d expected 751", sweep_done, t2 - t1); end
    for (int i = 0; i < 5 && ss_n == 7'h7F; i++) step();
    tests_run++;
    if ((cyc - t2) != 2) begin tests_failed++; $display("FAIL b2b_gap2: got %0d expected 2", cyc - t2); end
    for (int i = 0; i < 900 && !sweep_done; i++) step();
    tests_run++;
    if (!sweep_done || (cyc - t2) != 751) begin tests_failed++; $display("FAIL b2b_len2: done=%b spacing %0d expected 751", sweep_done, cyc - t2); end
    tests_run++;
    if ((n_start - s0) != 14) begin tests_failed++; $display("FAIL b2b_starts: got %0d expected 14", n_start - s0); end
    tests_run++;
    if (overrun !== 1'b1) begin tests_failed++; $display("FAIL b2b_overrun: got %b expected 1", overrun); end
  endtask

  task automatic test_power_loss();
    int sw0, st0;
    do_reset();
    enable_mask   = 7'b0001001;
    resp_delay    = 30;
    update_period = 32'd400;
    for (int i = 0; i < 600 && !(spi_start && motor_index == 3'd3); i++) step();
    tests_run++;
    if (!spi_start || motor_index !== 3'd3) begin tests_failed++; $display("FAIL pwr_reach3: start=%b idx=%0d expected 1 and 3", spi_start, motor_index); end
    repeat (5) step();
    sw0 = n_sweep;
    st0 = n_start;
    power_sense_n = 1'b1;
    step();
    tests_run++;
    if (ss_n !== 7'h7F) begin tests_failed++; $display("FAIL pwr_ss_n: got %h expected 7f", ss_n); end
    tests_run++;
    if (motor_index !== 3'd0) begin tests_failed++; $display("FAIL pwr_idx: got %0d expected 0", motor_index); end
    repeat (20) step();
    power_sense_n = 1'b0;
    for (int i = 0; i < 450 && ss_n == 7'h7F; i++) step();
    tests_run++;
    if (ss_n !== 7'b1111110 || motor_index !== 3'd0) begin tests_failed++; $display("FAIL pwr_restart: ss_n=%b idx=%0d expected 1111110 and 0", ss_n, motor_index); end
    tests_run++;
    if ((n_sweep - sw0) != 0 || (n_start - st0) != 0) begin tests_failed++; $display("FAIL pwr_quiet: sweeps=%0d starts=%0d expected 0 and 0", n_sweep - sw0, n_start - st0); end
  endtask

  task automatic test_empty_mask();
    int t1, t2, st0;
    do_reset();
    st0           = n_start;
    enable_mask   = 7'h00;
    update_period = 32'd30;
    for (int i = 0; i < 60 && !sweep_done; i++) step();
    t1 = cyc;
    step();
    for (int i = 0; i < 40 && !sweep_done; i++) step();
    t2 = cyc;
    tests_run++;
    if (!sweep_done || (t2 - t1) != 30) begin tests_failed++; $display("FAIL empty_period: done=%b spacing %0d expected 30", sweep_done, t2 - t1); end
    repeat (10) step();
    update_period = 32'd40;
    step();
    for (int i = 0; i < 60 && !sweep_done; i++) step();
    tests_run++;
    if (!sweep_done || (cyc - t2) != 53) begin tests_failed++; $display("FAIL period_change: done=%b after %0d expected 53", sweep_done, cyc - t2); end
    tests_run++;
    if ((n_start - st0) != 0) begin tests_failed++; $display("FAIL empty_starts: got %0d expected 0", n_start - st0); end
  endtask

  task automatic test_stray_and_reset();
    int st0;
    do_reset();
    st0      = n_start;
    stray_en = 1'b1;
    repeat (3) step();
    stray_en = 1'b0;
    repeat (3) step();
    tests_run++;
    if (ss_n !== 7'h7F || (n_start - st0) != 0) begin tests_failed++; $display("FAIL stray_done: ss_n=%h starts=%0d expected 7f and 0", ss_n, n_start - st0); end
    enable_mask   = 7'b0000001;
    resp_delay    = 10;
    update_period = 32'd10;
    for (int i = 0; i < 30 && ss_n == 7'h7F; i++) step();
    repeat (2) step();
    st0           = n_start;
    reset_n       = 1'b0;
    update_period = '0;
    step();
    tests_run++;
    if (ss_n !== 7'h7F || spi_start !== 1'b0 || sweep_done !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_out: ss_n=%h start=%b done=%b expected 7f 0 0", ss_n, spi_start, sweep_done); end
    tests_run++;
    if (motor_index !== 3'd0 || timeout_err !== 7'h00 || overrun !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_regs: idx=%0d tmo=%h ovr=%b expected 0 00 0", motor_index, timeout_err, overrun); end
    reset_n = 1'b1;
    repeat (20) step();
    tests_run++;
    if ((n_start - st0) != 0) begin tests_failed++; $display("FAIL rst_mid_nostart: got %0d expected 0", n_start - st0); end
  endtask

  initial begin
    reset_n       = 1'b0;
    update_period = '0;
    enable_mask   = '0;
    power_sense_n = 1'b0;
    clear_flags   = 1'b0;
    test_reset();
    test_sweep();
    test_timeout();
    test_clear_priority();
    test_back_to_back();
    test_power_loss();
    test_empty_mask();
    test_stray_and_reset();
    tests_run++;
    if (n_viol != 0) begin tests_failed++; $display("FAIL one_hot_ss: %0d cycles with several selects low, expected 0", n_viol); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
